// File: rtl/uart_arb_pkg.sv
// rtl/uart_arb_pkg.sv - shared state encoding, byte width and clog2 helper for UART arbitration
package uart_arb_pkg;

   localparam int BYTE_W = 8;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      ISSUE     = 2'd1,
      WAIT_BUSY = 2'd2,
      WAIT_DONE = 2'd3
   } arb_state_t;

   // Ceiling log2, never below 1 so a counter or index always has a bit.
   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// rtl/uart_tx_arbiter_if.sv - requester lanes and transmitter handshake bundled for the arbiter
interface uart_tx_arbiter_if
   import uart_arb_pkg::*;
#(
   parameter int NUM_REQ = 4
);
   localparam int OWNER_W = clog2(NUM_REQ);

   logic [NUM_REQ-1:0]        req;
   logic [NUM_REQ-1:0]        last;
   logic [BYTE_W*NUM_REQ-1:0] data;
   logic [NUM_REQ-1:0]        ack;
   logic [OWNER_W-1:0]        owner;
   logic                      owner_valid;
   logic [BYTE_W-1:0]         tx_data;
   logic                      tx_start;
   logic                      tx_busy;

   // Arbiter side: consumes requester lanes and the transmitter busy flag.
   modport slave (
      input  req, last, data, tx_busy,
      output ack, owner, owner_valid, tx_data, tx_start
   );

   // Environment side: requesters plus transmitter.
   modport master (
      output req, last, data, tx_busy,
      input  ack, owner, owner_valid, tx_data, tx_start
   );

endinterface

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - combinational round-robin first-set-bit search after last_owner
module rr_picker
   import uart_arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   localparam int IDX_W = clog2(NUM_REQ)
)(
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   last_owner,
   output logic [IDX_W-1:0]   pick,
   output logic               any
);

   int w_idx;

   // Scan from the farthest candidate back to the nearest so the first set bit after last_owner wins.
   always_comb begin
      pick  = '0;
      w_idx = 0;
      for (int i = NUM_REQ; i >= 1; i--) begin
         w_idx = (int'(last_owner) + i) % NUM_REQ;
         if (req[w_idx]) pick = IDX_W'(w_idx);
      end
   end

   assign any = |req;

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin packet arbiter sharing one UART transmitter
module uart_tx_arbiter
   import uart_arb_pkg::*;
#(
   parameter int NUM_REQ       = 4,
   parameter int MAX_BURST     = 16,
   parameter int START_TIMEOUT = 8
)(
   input logic clk,
   input logic nrst,
   uart_tx_arbiter_if.slave bus
);

   localparam int OW = clog2(NUM_REQ);
   localparam int BW = clog2(MAX_BURST + 1);
   localparam int TW = clog2(START_TIMEOUT);
   localparam logic [OW-1:0] LAST_IDX  = OW'(NUM_REQ - 1);
   localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);
   localparam logic [TW-1:0] TO_LAST   = TW'(START_TIMEOUT - 1);

   // Input samples: every FSM decision is taken from these, one cycle behind the pins.
   logic [NUM_REQ-1:0]        r_req_s;
   logic [NUM_REQ-1:0]        r_last_s;
   logic [BYTE_W*NUM_REQ-1:0] r_data_s;
   logic                      r_busy_s;

   arb_state_t                r_state;
   logic [OW-1:0]             r_owner;
   logic [OW-1:0]             r_last_owner;
   logic                      r_owner_valid;
   logic [NUM_REQ-1:0]        r_ack;
   logic                      r_tx_start;
   logic [BYTE_W-1:0]         r_tx_data;
   logic                      r_last_q;
   logic [BW-1:0]             r_burst_cnt;
   logic [TW-1:0]             r_timeout_cnt;

   logic [OW-1:0]             w_pick;
   logic                      w_any;
   logic [BYTE_W-1:0]         w_lane;
   logic [NUM_REQ-1:0]        w_owner_hot;

   rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
      .req        (r_req_s),
      .last_owner (r_last_owner),
      .pick       (w_pick),
      .any        (w_any)
   );

   assign w_lane      = r_data_s[BYTE_W*int'(r_owner) +: BYTE_W];
   assign w_owner_hot = NUM_REQ'(1) << r_owner;

   // Capture requester lanes and transmitter busy on the baud-domain clock.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_req_s  <= '0;
         r_last_s <= '0;
         r_data_s <= '0;
         r_busy_s <= 1'b0;
      end else begin
         r_req_s  <= bus.req;
         r_last_s <= bus.last;
         r_data_s <= bus.data;
         r_busy_s <= bus.tx_busy;
      end
   end

   // Grant, issue bytes one at a time off the busy flag, release on last byte or burst limit.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_state       <= IDLE;
         r_owner       <= '0;
         r_last_owner  <= LAST_IDX;
         r_owner_valid <= 1'b0;
         r_ack         <= '0;
         r_tx_start    <= 1'b0;
         r_tx_data     <= '0;
         r_last_q      <= 1'b0;
         r_burst_cnt   <= '0;
         r_timeout_cnt <= '0;
      end else begin
         r_ack      <= '0;
         r_tx_start <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_any) begin
                  r_owner       <= w_pick;
                  r_owner_valid <= 1'b1;
                  r_burst_cnt   <= '0;
                  r_state       <= ISSUE;
               end
            end
            ISSUE: begin
               if (!r_req_s[r_owner]) begin
                  r_last_owner  <= r_owner;
                  r_owner_valid <= 1'b0;
                  r_state       <= IDLE;
               end else if (!r_busy_s) begin
                  r_tx_data     <= w_lane;
                  r_tx_start    <= 1'b1;
                  r_ack         <= w_owner_hot;
                  r_last_q      <= r_last_s[r_owner];
                  r_burst_cnt   <= r_burst_cnt + 1'b1;
                  r_timeout_cnt <= '0;
                  r_state       <= WAIT_BUSY;
               end
            end
            WAIT_BUSY: begin
               // A transmitter that never acknowledges the start must not hang the grant.
               if (r_busy_s || (r_timeout_cnt == TO_LAST)) begin
                  r_state <= WAIT_DONE;
               end else begin
                  r_timeout_cnt <= r_timeout_cnt + 1'b1;
               end
            end
            WAIT_DONE: begin
               if (!r_busy_s) begin
                  if (r_last_q || (r_burst_cnt == BURST_MAX)) begin
                     r_last_owner  <= r_owner;
                     r_owner_valid <= 1'b0;
                     r_state       <= IDLE;
                  end else begin
                     r_state <= ISSUE;
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.ack         = r_ack;
   assign bus.owner       = r_owner;
   assign bus.owner_valid = r_owner_valid;
   assign bus.tx_data     = r_tx_data;
   assign bus.tx_start    = r_tx_start;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

   logic clk = 1'b0;
   logic nrst;
   int   cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   uart_tx_arbiter_if #(.NUM_REQ(4)) bus ();

   uart_tx_arbiter #(.NUM_REQ(4), .MAX_BURST(16), .START_TIMEOUT(8)) dut (
      .clk  (clk),
      .nrst (nrst),
      .bus  (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Per-lane byte queues: bit 8 is the last flag.
   logic [8:0] lane_buf [4][64];
   int         lane_head [4];
   int         lane_tail [4];

   // Issue log and expectations.
   int         iss_owner [$];
   logic [7:0] iss_data  [$];
   int         iss_cyc   [$];
   int         iss_fgap  [$];
   int         iss_sgap  [$];
   int         exp_owner [$];
   logic [7:0] exp_data  [$];

   int   req_rise_cyc [4];
   int   ov_rise_cyc = 0;
   logic ov_prev = 1'b0;
   int   busy_fall_cyc = -1000;
   int   prev_start_cyc = -1000;
   int   tx_hold = 4;
   logic tx_dead = 1'b0;
   int   busy_left = 0;
   int   mon_o;
   int   mdl_last = 3;

   typedef struct {
      logic [3:0]  mask;
      int          n;
      logic [15:0] order;
   } vec_t;
   vec_t vecs [7];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic lanes_empty();
      for (int i = 0; i < 4; i++) if (lane_head[i] < lane_tail[i]) return 1'b0;
      return 1'b1;
   endfunction

   task automatic clear_all();
      for (int i = 0; i < 4; i++) begin lane_head[i] = 0; lane_tail[i] = 0; end
      iss_owner.delete(); iss_data.delete(); iss_cyc.delete();
      iss_fgap.delete(); iss_sgap.delete();
      exp_owner.delete(); exp_data.delete();
   endtask

   task automatic push_byte(input int lane, input logic [7:0] d, input logic l);
      lane_buf[lane][lane_tail[lane]] = {l, d};
      lane_tail[lane]++;
   endtask

   task automatic load_pkt(input int lane, input int len, input logic [7:0] base);
      for (int k = 0; k < len; k++) push_byte(lane, 8'(base + k), (k == len - 1));
   endtask

   task automatic exp_push(input int o, input logic [7:0] d);
      exp_owner.push_back(o);
      exp_data.push_back(d);
   endtask

   // Reference: round-robin over lanes with pending bytes, whole packet or MAX_BURST bytes per grant.
   task automatic model_run();
      int h [4];
      int o;
      int n;
      logic found;
      logic [8:0] e;
      for (int i = 0; i < 4; i++) h[i] = lane_head[i];
      forever begin
         found = 1'b0;
         o = 0;
         for (int k = 1; k <= 4; k++) begin
            o = (mdl_last + k) % 4;
            if (h[o] < lane_tail[o]) begin found = 1'b1; break; end
         end
         if (!found) break;
         n = 0;
         do begin
            e = lane_buf[o][h[o]];
            h[o]++;
            exp_push(o, e[7:0]);
            n++;
         end while (!e[8] && n < 16 && h[o] < lane_tail[o]);
         mdl_last = o;
      end
   endtask

   task automatic cmp_run(input string name);
      chk({name, "_count"}, iss_owner.size(), exp_owner.size());
      for (int k = 0; k < iss_owner.size() && k < exp_owner.size(); k++) begin
         chk({name, "_owner"}, iss_owner[k], exp_owner[k]);
         chk({name, "_data"}, iss_data[k], exp_data[k]);
      end
   endtask

   task automatic drain(input int budget);
      int t;
      t = 0;
      do begin @(negedge clk); t++; end
      while (!(lanes_empty() && !bus.owner_valid && !bus.tx_busy) && t < budget);
      n_checks++;
      if (t >= budget) begin
         n_fail++;
         $display("FAIL drain_timeout: waited %0d cycles, required under %0d", t, budget);
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      nrst = 1'b0;
      clear_all();
      repeat (2) @(negedge clk);
      nrst = 1'b1;
      mdl_last = 3;
      @(negedge clk);
   endtask

   // Environment: monitor, requesters and transmitter model, all on the falling edge.
   initial begin
      bus.req = '0; bus.last = '0; bus.data = '0; bus.tx_busy = 1'b0;
      forever begin
         @(negedge clk);
         chk("start_ack_coincident", bus.tx_start, (bus.ack != 4'b0));
         chk("ack_onehot0", $onehot0(bus.ack), 1'b1);
         if (bus.tx_start === 1'b1) begin
            mon_o = int'(bus.owner);
            iss_owner.push_back(mon_o);
            iss_data.push_back(bus.tx_data);
            iss_cyc.push_back(cyc);
            iss_fgap.push_back(cyc - busy_fall_cyc);
            iss_sgap.push_back(cyc - prev_start_cyc);
            prev_start_cyc = cyc;
            chk("ack_is_owner", bus.ack, 4'b1 << mon_o);
            chk("ack_had_pending", (lane_head[mon_o] < lane_tail[mon_o]), 1'b1);
            if (lane_head[mon_o] < lane_tail[mon_o])
               chk("tx_data_lane", bus.tx_data, lane_buf[mon_o][lane_head[mon_o]][7:0]);
         end
         for (int i = 0; i < 4; i++) begin
            if (bus.ack[i] && lane_head[i] < lane_tail[i]) lane_head[i]++;
            if (lane_head[i] < lane_tail[i]) begin
               if (!bus.req[i]) req_rise_cyc[i] = cyc;
               bus.req[i]          = 1'b1;
               bus.data[8*i +: 8]  = lane_buf[i][lane_head[i]][7:0];
               bus.last[i]         = lane_buf[i][lane_head[i]][8];
            end else begin
               bus.req[i]          = 1'b0;
               bus.data[8*i +: 8]  = 8'h00;
               bus.last[i]         = 1'b0;
            end
         end
         if (bus.owner_valid && !ov_prev) ov_rise_cyc = cyc;
         ov_prev = bus.owner_valid;
         if (busy_left > 0) begin
            busy_left--;
            if (busy_left == 0) begin bus.tx_busy = 1'b0; busy_fall_cyc = cyc; end
         end
         if (bus.tx_start === 1'b1 && !tx_dead) begin
            bus.tx_busy = 1'b1;
            busy_left   = tx_hold;
         end
      end
   end

   initial begin
      vecs[0] = '{4'b0001, 1, 16'h0000};
      vecs[1] = '{4'b1111, 4, 16'h0321};
      vecs[2] = '{4'b1010, 2, 16'h0031};
      vecs[3] = '{4'b0110, 2, 16'h0021};
      vecs[4] = '{4'b1001, 2, 16'h0003};
      vecs[5] = '{4'b0100, 1, 16'h0002};
      vecs[6] = '{4'b0011, 2, 16'h0010};

      clear_all();
      nrst = 1'b0;
      #1;
      chk("rst_owner_valid", bus.owner_valid, 1'b0);
      chk("rst_owner", bus.owner, 2'd0);
      chk("rst_ack", bus.ack, 4'b0);
      chk("rst_tx_start", bus.tx_start, 1'b0);
      chk("rst_tx_data", bus.tx_data, 8'h00);
      repeat (3) @(negedge clk);
      nrst = 1'b1;
      @(negedge clk);

      // Single byte 0x41 on lane 0, 20-cycle frames, with grant/issue latency.
      tx_hold = 20;
      push_byte(0, 8'h41, 1'b1);
      exp_push(0, 8'h41);
      drain(200);
      cmp_run("single");
      chk("grant_latency", ov_rise_cyc - req_rise_cyc[0], 2);
      if (iss_cyc.size() > 0) chk("start_latency", iss_cyc[0] - req_rise_cyc[0], 3);
      chk("single_released", bus.owner_valid, 1'b0);

      // All four requesting, single-byte packets, lane 0 with two.
      do_reset();
      tx_hold = 3;
      load_pkt(0, 1, 8'h10); load_pkt(0, 1, 8'h11);
      load_pkt(1, 1, 8'h21); load_pkt(2, 1, 8'h22); load_pkt(3, 1, 8'h23);
      exp_push(0, 8'h10); exp_push(1, 8'h21); exp_push(2, 8'h22);
      exp_push(3, 8'h23); exp_push(0, 8'h11);
      drain(400);
      cmp_run("rr_all");

      // Table of request masks, grant order carried from one record to the next.
      do_reset();
      for (int r = 0; r < 7; r++) begin
         clear_all();
         for (int i = 0; i < 4; i++)
            if (vecs[r].mask[i]) push_byte(i, 8'(8'h30 + r*4 + i), 1'b1);
         for (int k = 0; k < vecs[r].n; k++)
            exp_push(int'(vecs[r].order[4*k +: 4]), 8'(8'h30 + r*4 + int'(vecs[r].order[4*k +: 4])));
         drain(400);
         cmp_run("table");
      end

      // 20-byte packet on lane 2 split at 16 bytes, lane 1 served in between.
      clear_all();
      tx_hold = 2;
      load_pkt(2, 20, 8'hA0);
      load_pkt(1, 1, 8'h55);
      for (int k = 0; k < 16; k++) exp_push(2, 8'(8'hA0 + k));
      exp_push(1, 8'h55);
      for (int k = 16; k < 20; k++) exp_push(2, 8'(8'hA0 + k));
      drain(2000);
      cmp_run("burst");

      // Busy-low to next start: within a packet, and across a release.
      clear_all();
      tx_hold = 4;
      load_pkt(3, 2, 8'h60);
      load_pkt(0, 1, 8'h70);
      exp_push(3, 8'h60); exp_push(3, 8'h61); exp_push(0, 8'h70);
      drain(400);
      cmp_run("gap");
      if (iss_fgap.size() == 3) begin
         chk("gap_in_packet", iss_fgap[1], 3);
         chk("gap_after_release", iss_fgap[2], 4);
      end

      // Transmitter never raises busy: start timeout paces the bytes.
      clear_all();
      tx_dead = 1'b1;
      load_pkt(1, 2, 8'h80);
      exp_push(1, 8'h80); exp_push(1, 8'h81);
      drain(400);
      cmp_run("timeout");
      if (iss_sgap.size() == 2) chk("timeout_start_gap", iss_sgap[1], 10);
      tx_dead = 1'b0;

      // Requester withdraws after its first byte without marking it last.
      clear_all();
      tx_hold = 6;
      push_byte(2, 8'h90, 1'b0);
      drain(400);
      chk("withdraw_starts", iss_owner.size(), 1);
      chk("withdraw_released", bus.owner_valid, 1'b0);
      clear_all();
      load_pkt(2, 1, 8'h92); load_pkt(3, 1, 8'h93);
      exp_push(3, 8'h93); exp_push(2, 8'h92);
      drain(400);
      cmp_run("after_withdraw");

      // Asynchronous reset while a frame is in flight.
      clear_all();
      tx_hold = 20;
      load_pkt(3, 3, 8'hC0);
      for (int t = 0; t < 50 && iss_owner.size() == 0; t++) @(negedge clk);
      chk("prereset_started", iss_owner.size(), 1);
      repeat (5) @(negedge clk);
      chk("prereset_grant", bus.owner_valid, 1'b1);
      nrst = 1'b0;
      #1;
      chk("arst_owner_valid", bus.owner_valid, 1'b0);
      chk("arst_owner", bus.owner, 2'd0);
      chk("arst_ack", bus.ack, 4'b0);
      chk("arst_tx_start", bus.tx_start, 1'b0);
      chk("arst_tx_data", bus.tx_data, 8'h00);
      clear_all();
      repeat (2) @(negedge clk);
      nrst = 1'b1;
      for (int t = 0; t < 60 && bus.tx_busy; t++) @(negedge clk);
      clear_all();
      load_pkt(0, 1, 8'hD0); load_pkt(2, 1, 8'hD2);
      exp_push(0, 8'hD0); exp_push(2, 8'hD2);
      drain(400);
      cmp_run("post_reset");

      // Randomized packets against the reference model.
      mdl_last = 2;
      for (int rnd = 0; rnd < 3; rnd++) begin
         clear_all();
         tx_hold = $urandom_range(2, 6);
         tx_dead = ($urandom_range(0, 3) == 0);
         for (int i = 0; i < 4; i++) begin
            int npk;
            npk = $urandom_range(0, 3);
            for (int p = 0; p < npk; p++) load_pkt(i, $urandom_range(1, 20), 8'($urandom));
         end
         model_run();
         drain(8000);
         cmp_run("random");
      end
      tx_dead = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
